// File: rtl/robot_pkg.sv
// Shared definitions for the robot controller scoreboard: FSM states and
// parameter limits. Optional feature macro: ROBOT_SCB_FIRST_FAIL_EN.
package robot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scb_state_e;

  localparam int MAX_CH  = 8;
  localparam int MAX_LAT = 7;

  // Width of a channel index, never narrower than one bit.
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/robot_scoreboard_delay_line.sv
// Fixed-depth shift register that delays the expected stream. DEPTH=0 is a
// plain passthrough. flush_i empties every stage at the next clock edge.
module scb_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst, flush_i};
      assign q_o = d_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift one stage per clock; reset and flush empty the line.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (flush_i) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/robot_scoreboard.sv
// Compares a delayed expected forward/rotate stream against N_CH robot
// controllers, counting samples and per-channel mismatches with saturation.
// Optional macro ROBOT_SCB_FIRST_FAIL_EN captures the first mismatch location.
module robot_scoreboard
  import robot_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int LAT   = 0,
  parameter int CNT_W = 16,
  localparam int CH_W = ch_idx_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sample_valid,
  input  logic                  exp_f,
  input  logic                  exp_r,
  input  logic [N_CH-1:0]       dut_f,
  input  logic [N_CH-1:0]       dut_r,
  input  logic                  end_of_stream,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      sample_cnt,
  output logic [N_CH*CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0]      fail_cycle,
  output logic [CH_W-1:0]       fail_ch
);

  localparam int               DRAIN_W  = $clog2(MAX_LAT + 1);
  localparam logic [DRAIN_W-1:0] LAT_M1 = (LAT > 0) ? DRAIN_W'(LAT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  scb_state_e           state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
  logic [N_CH*CNT_W-1:0] err_q, err_d;
  logic                 done_q, done_d, pass_q, pass_d;

  logic                 clear_s, push_s, cmp_s, finish_s;
  logic [2:0]           line_in_s, line_out_s;
  logic [N_CH-1:0]      mism_s;

  // A new run may only begin from IDLE or DONE; the same edge wipes all state.
  assign clear_s  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign push_s   = sample_valid && (state_q == ST_RUN);
  assign line_in_s = {exp_f, exp_r, push_s};
  assign cmp_s    = line_out_s[0] && (state_q == ST_RUN || state_q == ST_DRAIN);
  assign finish_s = (state_d == ST_DONE) && (state_q != ST_DONE);

  scb_delay_line #(.WIDTH(3), .DEPTH(LAT)) u_delay (
    .clk     (clk),
    .rst     (reset),
    .flush_i (clear_s),
    .d_i     (line_in_s),
    .q_o     (line_out_s)
  );

  // Per-channel mismatch against the entry leaving the delay line.
  always_comb begin
    mism_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      mism_s[i] = (dut_f[i] != line_out_s[2]) || (dut_r[i] != line_out_s[1]);
    end
  end

  // Next-state logic: DRAIN counts down LAT cycles before DONE.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_RUN;
        else       state_d = state_q;
      end
      ST_RUN: begin
        if (end_of_stream) begin
          if (LAT == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
            drain_d = LAT_M1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_DONE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating counters and the done/pass verdict computed at run end.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_d        = err_q;
    done_d       = done_q;
    pass_d       = pass_q;
    if (clear_s) begin
      sample_cnt_d = '0;
      err_d        = '0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
    end else begin
      if (cmp_s && (sample_cnt_q != CNT_MAX)) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      else                                     sample_cnt_d = sample_cnt_q;
      for (int i = 0; i < N_CH; i++) begin
        if (cmp_s && mism_s[i] && (err_q[i*CNT_W +: CNT_W] != CNT_MAX))
          err_d[i*CNT_W +: CNT_W] = err_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        else
          err_d[i*CNT_W +: CNT_W] = err_q[i*CNT_W +: CNT_W];
      end
      if (finish_s) begin
        done_d = 1'b1;
        pass_d = (err_d == '0);
      end else begin
        done_d = done_q;
        pass_d = pass_q;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      drain_q      <= '0;
      sample_cnt_q <= '0;
      err_q        <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      sample_cnt_q <= sample_cnt_d;
      err_q        <= err_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign done       = done_q;
  assign pass       = pass_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_q;

`ifdef ROBOT_SCB_FIRST_FAIL_EN
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] fail_cycle_q, fail_cycle_d;
  logic [CH_W-1:0]  fail_ch_q, fail_ch_d, low_ch_s;

  // Lowest-numbered mismatching channel in the compare cycle.
  always_comb begin
    low_ch_s = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mism_s[i]) low_ch_s = CH_W'(i);
      else           low_ch_s = low_ch_s;
    end
  end

  // Capture location of the first mismatch in a run, then hold.
  always_comb begin
    seen_d       = seen_q;
    fail_cycle_d = fail_cycle_q;
    fail_ch_d    = fail_ch_q;
    if (clear_s) begin
      seen_d       = 1'b0;
      fail_cycle_d = '0;
      fail_ch_d    = '0;
    end else if (cmp_s && (|mism_s) && !seen_q) begin
      seen_d       = 1'b1;
      fail_cycle_d = sample_cnt_q;
      fail_ch_d    = low_ch_s;
    end else begin
      seen_d       = seen_q;
    end
  end

  // First-fail capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_q       <= 1'b0;
      fail_cycle_q <= '0;
      fail_ch_q    <= '0;
    end else begin
      seen_q       <= seen_d;
      fail_cycle_q <= fail_cycle_d;
      fail_ch_q    <= fail_ch_d;
    end
  end

  assign fail_cycle = fail_cycle_q;
  assign fail_ch    = fail_ch_q;
`else
  assign fail_cycle = '0;
  assign fail_ch    = '0;
`endif

endmodule

// File: tb/tb_robot_scoreboard.sv
// Scoreboard bench for robot_scoreboard: randomized runs, expected results
// derived from the sample list, popped by a monitor when done rises.
module tb_robot_scoreboard;
  localparam int N_CH  = 2;
  localparam int LAT   = 3;
  localparam int CNT_W = 4;
  localparam int CH_W  = 1;
  localparam int MAXC  = 80;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, sample_valid = 1'b0;
  logic exp_f = 1'b0, exp_r = 1'b0, end_of_stream = 1'b0;
  logic [N_CH-1:0] dut_f = '0, dut_r = '0;
  logic done, pass;
  logic [CNT_W-1:0] sample_cnt, fail_cycle;
  logic [N_CH*CNT_W-1:0] err_cnt;
  logic [CH_W-1:0] fail_ch;

  robot_scoreboard #(.N_CH(N_CH), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .exp_f(exp_f), .exp_r(exp_r), .dut_f(dut_f), .dut_r(dut_r),
    .end_of_stream(end_of_stream), .done(done), .pass(pass),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .fail_cycle(fail_cycle),
    .fail_ch(fail_ch));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0]      scnt;
    logic [N_CH*CNT_W-1:0] err;
    logic                  pass;
    logic [CNT_W-1:0]      fcyc;
    logic [CH_W-1:0]       fch;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic done_prev = 1'b0;
  int n_cmp = 0, n_fail = 0;

  logic drv_v[MAXC], drv_ef[MAXC], drv_er[MAXC], drv_eos[MAXC], drv_st[MAXC];
  logic [N_CH-1:0] drv_df[MAXC], drv_dr[MAXC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: when done rises, pop the expected result and compare it.
  always @(negedge clk) begin
    done_prev <= done;
    if (done === 1'b1 && done_prev !== 1'b1 && !reset) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sample_cnt", 64'(sample_cnt), 64'(mon_e.scnt));
        check("err_cnt",    64'(err_cnt),    64'(mon_e.err));
        check("pass",       64'(pass),       64'(mon_e.pass));
        check("fail_cycle", 64'(fail_cycle), 64'(mon_e.fcyc));
        check("fail_ch",    64'(fail_ch),    64'(mon_e.fch));
      end
    end
  end

  task automatic drive_idle();
    start = 1'b0; sample_valid = 1'b0; end_of_stream = 1'b0;
    exp_f = 1'b0; exp_r = 1'b0; dut_f = '0; dut_r = '0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({done, pass, sample_cnt, err_cnt, fail_cycle, fail_ch}), 64'd0);
  endtask

  // mode: 0 match, 1 random errors, 2 all wrong, 3 both chans wrong at sample 5,
  // 4 ch0 rotate wrong at sample 3
  task automatic do_run(input int n, input int mode, input bit abort);
    int pos, t0, first_k, first_ch;
    int cnt_err[N_CH];
    logic ef, er;
    logic [N_CH-1:0] df, dr;
    exp_t e;
    for (int c = 0; c < MAXC; c++) begin
      drv_v[c] = 1'b0; drv_eos[c] = 1'b0; drv_st[c] = 1'b0;
      drv_ef[c] = 1'($urandom); drv_er[c] = 1'($urandom);
      drv_df[c] = N_CH'($urandom); drv_dr[c] = N_CH'($urandom);
    end
    for (int i = 0; i < N_CH; i++) cnt_err[i] = 0;
    first_k = -1; first_ch = 0; pos = 0; t0 = 0;
    for (int k = 0; k < n; k++) begin
      pos = pos + $urandom_range(0, 2);
      ef = 1'($urandom); er = 1'($urandom);
      df = {N_CH{ef}}; dr = {N_CH{er}};
      case (mode)
        1: for (int i = 0; i < N_CH; i++) begin
             if ($urandom_range(0, 4) == 0) df[i] = ~df[i];
             if ($urandom_range(0, 4) == 0) dr[i] = ~dr[i];
           end
        2: df = ~df;
        3: if (k == 5) df = ~df;
        4: if (k == 3) dr[0] = ~dr[0];
        default: ;
      endcase
      drv_v[pos] = 1'b1; drv_ef[pos] = ef; drv_er[pos] = er;
      drv_df[pos + LAT] = df; drv_dr[pos + LAT] = dr;
      for (int i = 0; i < N_CH; i++) begin
        if (df[i] != ef || dr[i] != er) begin
          cnt_err[i]++;
          if (first_k < 0) begin first_k = k; first_ch = i; end
        end
      end
      t0 = pos;
      pos = pos + 1;
    end
    drv_eos[t0] = 1'b1;
    for (int c = 1; c <= t0 + LAT; c++) begin
      if ($urandom_range(0, 7) == 0) drv_st[c] = 1'b1;
      if (c > t0) begin
        drv_v[c] = 1'($urandom);
        drv_eos[c] = 1'($urandom);
      end
    end
    e.scnt = CNT_W'((n > SAT) ? SAT : n);
    e.pass = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      e.err[i*CNT_W +: CNT_W] = CNT_W'((cnt_err[i] > SAT) ? SAT : cnt_err[i]);
      if (cnt_err[i] != 0) e.pass = 1'b0;
    end
`ifdef ROBOT_SCB_FIRST_FAIL_EN
    e.fcyc = (first_k < 0) ? '0 : CNT_W'((first_k > SAT) ? SAT : first_k);
    e.fch  = (first_k < 0) ? '0 : CH_W'(first_ch);
`else
    e.fcyc = '0;
    e.fch  = '0;
`endif
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= t0 + LAT; c++) begin
      start = drv_st[c]; sample_valid = drv_v[c]; end_of_stream = drv_eos[c];
      exp_f = drv_ef[c]; exp_r = drv_er[c]; dut_f = drv_df[c]; dut_r = drv_dr[c];
      if (c == t0 && !abort) sb_q.push_back(e);
      if (abort && c == t0 + 2) begin
        reset = 1'b1;
        #2;
        check_all_zero("reset_mid_drain");
        @(posedge clk); #1;
        reset = 1'b0;
        drive_idle();
        return;
      end
      if (c == t0 + LAT) check("done_early", 64'(done), 64'd0);
      @(posedge clk); #1;
    end
    drive_idle();
    check("done_latency", 64'(done), 64'd1);
    for (int h = 0; h < 4; h++) begin
      sample_valid = 1'($urandom); end_of_stream = 1'($urandom);
      exp_f = 1'($urandom); dut_f = N_CH'($urandom);
      @(posedge clk); #1;
    end
    drive_idle();
    check("hold_sample_cnt", 64'(sample_cnt), 64'(e.scnt));
    check("hold_err_cnt",    64'(err_cnt),    64'(e.err));
    check("hold_done_pass",  64'({done, pass}), 64'({1'b1, e.pass}));
  endtask

  initial begin
    drive_idle();
    #22;
    check_all_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle_after_reset");
    do_run(10, 0, 1'b0);
    do_run(8, 4, 1'b0);
    do_run(8, 3, 1'b0);
    do_run(20, 2, 1'b0);
    for (int r = 0; r < 6; r++) do_run($urandom_range(6, 20), 1, 1'b0);
    do_run(10, 1, 1'b1);
    check_all_zero("idle_after_abort");
    do_run(10, 0, 1'b0);
    do_run(9, 4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/robot_scoreboard.md
ROBOT_SCOREBOARD -- requirements
Module: robot_scoreboard

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of robot controller channels checked in parallel (1..8).
REQ-002 SHALL have parameter LAT, default 0: cycles the expected stream is delayed before comparison (0..7).
REQ-003 SHALL have parameter CNT_W, default 16: width of every counter.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins a checking run.
REQ-007 SHALL have port sample_valid  input  1  exp_f/exp_r hold a new map line this cycle.
REQ-008 SHALL have port exp_f, exp_r  input  1 each  expected forward/rotate for the sample.
REQ-009 SHALL have port dut_f, dut_r  input  N_CH each  per-channel forward/rotate from the controllers under check.
REQ-010 SHALL have port end_of_stream  input  1  pulse; last sample has been presented.
REQ-011 SHALL have port done, pass  output  1 each  run finished; finished with zero mismatches.
REQ-012 SHALL have port sample_cnt  output  CNT_W  samples compared in the current run.
REQ-013 SHALL have port err_cnt  output  N_CH*CNT_W  per-channel mismatch counters, channel i at bits [i*CNT_W +: CNT_W].
REQ-014 SHALL have port fail_cycle, fail_ch  output  CNT_W, clog2(N_CH) (min 1)  sample index and channel of first mismatch.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DRAIN, DONE; state leaves reset in IDLE.
REQ-016 IDLE or DONE + start -> RUN next cycle; entering RUN clears sample_cnt, err_cnt, fail_*, done, pass, and the delay line.
REQ-017 In RUN, each sample_valid SHALL push {exp_f, exp_r, valid} into a LAT-stage delay line; LAT=0 means no delay.
REQ-018 When a valid entry leaves the delay line, that cycle SHALL compare it with dut_f/dut_r of every channel (undelayed) and increment sample_cnt.
REQ-019 Channel i mismatches when dut_f[i]!=exp_f or dut_r[i]!=exp_r; err_cnt[i] SHALL increment by one per mismatching sample.
REQ-020 All counters SHALL saturate at all-ones; no wrap-around.
REQ-021 RUN + end_of_stream -> DRAIN; a sample_valid in the same cycle SHALL still be accepted.
REQ-022 DRAIN SHALL last exactly LAT cycles (zero for LAT=0, direct to DONE); in-flight entries keep being compared; new sample_valid ignored.
REQ-023 DONE: done=1; pass=1 iff every err_cnt is zero; counters hold until next start.
REQ-024 start in RUN or DRAIN SHALL be ignored; sample_valid in IDLE/DONE ignored; end_of_stream outside RUN ignored.
REQ-025 Output registers SHALL update one cycle after the compare cycle (registered outputs, no combinational paths from inputs).

Reset
REQ-026 reset SHALL asynchronously force state IDLE, delay line empty, and done, pass, sample_cnt, err_cnt, fail_cycle, fail_ch to 0.
REQ-027 reset mid-run SHALL discard all in-flight samples; no compare happens in the cycle reset deasserts.

Configuration
REQ-028 With ROBOT_SCB_FIRST_FAIL_EN defined, SHALL latch fail_cycle (sample_cnt value before increment) and fail_ch (lowest mismatching index) at the first mismatch of a run, then hold.
REQ-029 Without ROBOT_SCB_FIRST_FAIL_EN, fail_cycle and fail_ch SHALL be tied to 0 and no capture registers exist.

Structure
REQ-030 Shared package robot_pkg SHALL hold the FSM state enum and parameter limits (MAX_CH=8, MAX_LAT=7).
REQ-031 The delay line SHALL be sub-module scb_delay_line (parameters WIDTH, DEPTH; DEPTH=0 passthrough).

Verification
REQ-032 N_CH=2, LAT=0, 10 samples all matching, end_of_stream -> done=1, pass=1, sample_cnt=10, err_cnt=0.
REQ-033 N_CH=2, LAT=1, channel 1 delayed by one cycle, 8 samples, DUT r wrong on sample 3 for ch0 -> err_cnt[0]=1, err_cnt[1]=0, fail_cycle=3, fail_ch=0 (macro on).
REQ-034 Both channels mismatch on sample 5 simultaneously -> fail_ch=0, each err_cnt=1, pass=0.
REQ-035 CNT_W=4, 20 mismatching samples -> err_cnt saturates at 15, sample_cnt at 15.
REQ-036 reset asserted mid-DRAIN with LAT=3 -> all outputs 0, state IDLE; following start+run behaves as fresh.
REQ-037 Macro off, mismatch present -> fail_cycle=0, fail_ch=0, err_cnt still correct.
